// File: rtl/write_back_stage.sv
// ============================================================================
// write_back_stage
//
// Final stage of the MIPS pipeline: the MEM/WB pipeline register followed by
// the write-back selection logic that drives the register-file write port
// consumed by the decode stage.
//
// Each captured instruction performs exactly one register-file write and is
// counted exactly once, no matter how long the stage is stalled afterwards.
//
// Optional feature (macro WB_BYPASS_EN):
//   When defined, a one-entry write-history register records the most recent
//   retiring write for one cycle so decode can correct a read that happened
//   in the cycle right after the register-file write. When undefined, no
//   history state is built and the bypass outputs are tied to zero.
//
// Parameters:
//   DATA_WIDTH      width of ALU result, memory data and write data
//   REG_ADDR_WIDTH  register address width
//   COUNT_WIDTH     width of the retired-instruction counter
//
// Ports:
//   clk                input   clock, rising-edge active
//   reset              input   asynchronous reset, active low
//   stall              input   hold the pipeline register
//   flush              input   capture a bubble (overrides stall)
//   validIn            input   memory stage holds a real instruction
//   regWriteIn         input   instruction writes a register
//   memToRegIn         input   1: write memReadData, 0: write aluResult
//   regDstIn           input   1: destination is rd, 0: destination is rt
//   aluResult          input   ALU result from the memory stage
//   memReadData        input   data-memory read data
//   addressRegisterRt  input   rt field
//   addressRegisterRd  input   rd field
//   regWriteOut        output  register-file write enable
//   writeRegister      output  destination register
//   writeData          output  data to write
//   validOut           output  stage holds a valid instruction
//   retiredCount       output  retired-instruction count (wraps silently)
//   bypassValid        output  write-history entry valid
//   bypassRegister     output  write-history destination register
//   bypassData         output  write-history data
// ============================================================================
module write_back_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      validIn,
    input  logic                      regWriteIn,
    input  logic                      memToRegIn,
    input  logic                      regDstIn,
    input  logic [DATA_WIDTH-1:0]     aluResult,
    input  logic [DATA_WIDTH-1:0]     memReadData,
    input  logic [REG_ADDR_WIDTH-1:0] addressRegisterRt,
    input  logic [REG_ADDR_WIDTH-1:0] addressRegisterRd,
    output logic                      regWriteOut,
    output logic [REG_ADDR_WIDTH-1:0] writeRegister,
    output logic [DATA_WIDTH-1:0]     writeData,
    output logic                      validOut,
    output logic [COUNT_WIDTH-1:0]    retiredCount,
    output logic                      bypassValid,
    output logic [REG_ADDR_WIDTH-1:0] bypassRegister,
    output logic [DATA_WIDTH-1:0]     bypassData
);

    // ------------------------------------------------------------------
    // Pipeline register fields
    // ------------------------------------------------------------------
    logic                      validQ;
    logic                      regWriteQ;
    logic                      memToRegQ;
    logic                      regDstQ;
    logic [DATA_WIDTH-1:0]     aluResultQ;
    logic [DATA_WIDTH-1:0]     memReadDataQ;
    logic [REG_ADDR_WIDTH-1:0] rtQ;
    logic [REG_ADDR_WIDTH-1:0] rdQ;

    // Set once the held instruction has had its single write/retirement,
    // so a stall cannot repeat either.
    logic                      doneQ;

    logic                      retire;
    logic [COUNT_WIDTH-1:0]    retiredCountQ;

    // ------------------------------------------------------------------
    // Pipeline register. Flush wins over stall; a bubble's payload fields
    // are cleared so idle outputs stay quiet. The done flag is cleared on
    // every capture and only set while the instruction is held by a stall,
    // because without a stall a fresh capture replaces it anyway.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validQ       <= 1'b0;
            regWriteQ    <= 1'b0;
            memToRegQ    <= 1'b0;
            regDstQ      <= 1'b0;
            aluResultQ   <= '0;
            memReadDataQ <= '0;
            rtQ          <= '0;
            rdQ          <= '0;
            doneQ        <= 1'b0;
        end else if (flush) begin
            validQ       <= 1'b0;
            regWriteQ    <= 1'b0;
            memToRegQ    <= 1'b0;
            regDstQ      <= 1'b0;
            aluResultQ   <= '0;
            memReadDataQ <= '0;
            rtQ          <= '0;
            rdQ          <= '0;
            doneQ        <= 1'b0;
        end else if (!stall) begin
            validQ       <= validIn;
            regWriteQ    <= regWriteIn;
            memToRegQ    <= memToRegIn;
            regDstQ      <= regDstIn;
            aluResultQ   <= aluResult;
            memReadDataQ <= memReadData;
            rtQ          <= addressRegisterRt;
            rdQ          <= addressRegisterRd;
            doneQ        <= 1'b0;
        end else if (retire) begin
            doneQ        <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write-back selection, purely from the registered fields.
    // Writes to $zero are dropped here so the register file never sees them.
    // ------------------------------------------------------------------
    always_comb begin
        writeRegister = regDstQ ? rdQ : rtQ;
        writeData     = memToRegQ ? memReadDataQ : aluResultQ;
        retire        = validQ & ~doneQ;
        regWriteOut   = retire & regWriteQ & (writeRegister != '0);
        validOut      = validQ;
    end

    // ------------------------------------------------------------------
    // Retired-instruction counter. Every instruction that leaves the stage
    // counts, including non-writing ones and writes to $zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retiredCountQ <= '0;
        end else if (retire) begin
            retiredCountQ <= retiredCountQ + COUNT_WIDTH'(1);
        end
    end

    assign retiredCount = retiredCountQ;

`ifdef WB_BYPASS_EN
    // ------------------------------------------------------------------
    // One-entry write history. The valid bit lives for exactly the cycle
    // after a retiring write; address and data simply hold their last
    // value since they are meaningless while the valid bit is low.
    // ------------------------------------------------------------------
    logic                      bypassValidQ;
    logic [REG_ADDR_WIDTH-1:0] bypassRegisterQ;
    logic [DATA_WIDTH-1:0]     bypassDataQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bypassValidQ    <= 1'b0;
            bypassRegisterQ <= '0;
            bypassDataQ     <= '0;
        end else if (regWriteOut) begin
            bypassValidQ    <= 1'b1;
            bypassRegisterQ <= writeRegister;
            bypassDataQ     <= writeData;
        end else begin
            bypassValidQ    <= 1'b0;
        end
    end

    assign bypassValid    = bypassValidQ;
    assign bypassRegister = bypassRegisterQ;
    assign bypassData     = bypassDataQ;
`else
    assign bypassValid    = 1'b0;
    assign bypassRegister = '0;
    assign bypassData     = '0;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// ============================================================================
// tb_write_back_stage
//
// Self-checking bench for write_back_stage. A main instance uses the default
// parameters; a second instance with COUNT_WIDTH=4 shares the same inputs so
// counter wrap-around can be observed. Expected values come from an
// instruction-level reference model: one record for the instruction held in
// the stage (destination, data, already-retired flag), a retirement count and
// the last-write history. Bypass expectations follow WB_BYPASS_EN.
// ============================================================================
module tb_write_back_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        validIn;
    logic        regWriteIn;
    logic        memToRegIn;
    logic        regDstIn;
    logic [31:0] aluResult;
    logic [31:0] memReadData;
    logic [4:0]  addressRegisterRt;
    logic [4:0]  addressRegisterRd;

    logic        regWriteOut;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        validOut;
    logic [31:0] retiredCount;
    logic        bypassValid;
    logic [4:0]  bypassRegister;
    logic [31:0] bypassData;

    logic        sRegWriteOut;
    logic [4:0]  sWriteRegister;
    logic [31:0] sWriteData;
    logic        sValidOut;
    logic [3:0]  sRetiredCount;
    logic        sBypassValid;
    logic [4:0]  sBypassRegister;
    logic [31:0] sBypassData;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          mValid;
    bit          mWrites;
    bit [4:0]    mDest;
    bit [31:0]   mData;
    bit          mRetired;
    int unsigned mCount;
    bit          mBypValid;
    bit [4:0]    mBypReg;
    bit [31:0]   mBypData;

    write_back_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .validIn(validIn), .regWriteIn(regWriteIn), .memToRegIn(memToRegIn),
        .regDstIn(regDstIn), .aluResult(aluResult), .memReadData(memReadData),
        .addressRegisterRt(addressRegisterRt), .addressRegisterRd(addressRegisterRd),
        .regWriteOut(regWriteOut), .writeRegister(writeRegister),
        .writeData(writeData), .validOut(validOut), .retiredCount(retiredCount),
        .bypassValid(bypassValid), .bypassRegister(bypassRegister),
        .bypassData(bypassData)
    );

    write_back_stage #(.COUNT_WIDTH(4)) smallDut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .validIn(validIn), .regWriteIn(regWriteIn), .memToRegIn(memToRegIn),
        .regDstIn(regDstIn), .aluResult(aluResult), .memReadData(memReadData),
        .addressRegisterRt(addressRegisterRt), .addressRegisterRd(addressRegisterRd),
        .regWriteOut(sRegWriteOut), .writeRegister(sWriteRegister),
        .writeData(sWriteData), .validOut(sValidOut), .retiredCount(sRetiredCount),
        .bypassValid(sBypassValid), .bypassRegister(sBypassRegister),
        .bypassData(sBypassData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model. Destination and data are only
    // meaningful while the stage holds a valid instruction.
    task automatic checkOutput(input string tag);
        bit expWrite;
        expWrite = mValid && mWrites && !mRetired && (mDest != 5'd0);
        checkVal({tag, ".regWriteOut"}, {31'd0, regWriteOut}, {31'd0, expWrite});
        checkVal({tag, ".validOut"}, {31'd0, validOut}, {31'd0, mValid});
        if (mValid) begin
            checkVal({tag, ".writeRegister"}, {27'd0, writeRegister}, {27'd0, mDest});
            checkVal({tag, ".writeData"}, writeData, mData);
        end
        checkVal({tag, ".retiredCount"}, retiredCount, mCount);
        checkVal({tag, ".smallCount"}, {28'd0, sRetiredCount}, {28'd0, mCount[3:0]});
`ifdef WB_BYPASS_EN
        checkVal({tag, ".bypassValid"}, {31'd0, bypassValid}, {31'd0, mBypValid});
        if (mBypValid) begin
            checkVal({tag, ".bypassRegister"}, {27'd0, bypassRegister}, {27'd0, mBypReg});
            checkVal({tag, ".bypassData"}, bypassData, mBypData);
        end
`else
        checkVal({tag, ".bypassValid"}, {31'd0, bypassValid}, 32'd0);
        checkVal({tag, ".bypassRegister"}, {27'd0, bypassRegister}, 32'd0);
        checkVal({tag, ".bypassData"}, bypassData, 32'd0);
`endif
    endtask

    task automatic modelReset();
        mValid = 0; mWrites = 0; mDest = 0; mData = 0; mRetired = 0;
        mCount = 0; mBypValid = 0; mBypReg = 0; mBypData = 0;
    endtask

    // Advance the model across one rising edge using the current inputs:
    // the held instruction retires first, then the capture decision applies.
    task automatic modelEdge();
        bit retiring;
        retiring = mValid && !mRetired;
        if (retiring && mWrites && mDest != 5'd0) begin
            mBypValid = 1; mBypReg = mDest; mBypData = mData;
        end else begin
            mBypValid = 0;
        end
        if (retiring) begin
            mCount++;
            mRetired = 1;
        end
        if (flush) begin
            mValid = 0;
            mRetired = 0;
        end else if (!stall) begin
            mValid   = validIn;
            mWrites  = regWriteIn;
            mDest    = regDstIn ? addressRegisterRd : addressRegisterRt;
            mData    = memToRegIn ? memReadData : aluResult;
            mRetired = 0;
        end
    endtask

    // Drive one cycle of inputs, cross the edge, then check at the falling edge.
    task automatic applyStimulus(input string tag, input bit v, input bit rw,
                                 input bit m2r, input bit dst, input bit st,
                                 input bit fl, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic [4:0] rt,
                                 input logic [4:0] rd);
        validIn = v; regWriteIn = rw; memToRegIn = m2r; regDstIn = dst;
        stall = st; flush = fl; aluResult = alu; memReadData = mem;
        addressRegisterRt = rt; addressRegisterRd = rd;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0);
    endtask

    task automatic doReset();
        reset = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; stall = 0; flush = 0; validIn = 0; regWriteIn = 0;
        memToRegIn = 0; regDstIn = 0; aluResult = 0; memReadData = 0;
        addressRegisterRt = 0; addressRegisterRd = 0;
        modelReset();
        @(negedge clk);
        checkOutput("resetState");
        doReset();

        // Asynchronous reset while an instruction is loaded
        applyStimulus("preload", 1, 1, 0, 1, 0, 0, 32'h1111, 32'h2222, 5'd2, 5'd5);
        @(posedge clk);
        modelEdge();
        validIn = 0;
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkVal("asyncReset.regWriteOut", {31'd0, regWriteOut}, 32'd0);
        checkVal("asyncReset.writeRegister", {27'd0, writeRegister}, 32'd0);
        checkVal("asyncReset.writeData", writeData, 32'd0);
        checkVal("asyncReset.validOut", {31'd0, validOut}, 32'd0);
        checkVal("asyncReset.retiredCount", retiredCount, 32'd0);
        checkVal("asyncReset.bypassValid", {31'd0, bypassValid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle("afterReset");

        // Basic write from memory data into rt
        applyStimulus("basic", 1, 1, 1, 0, 0, 0, 32'h0BAD0BAD, 32'hCAFEF00D, 5'd9, 5'd17);
        checkVal("basic.writeData.const", writeData, 32'hCAFEF00D);
        checkVal("basic.writeRegister.const", {27'd0, writeRegister}, 32'd9);
        idle("basicRetire");
        checkVal("basic.count.const", retiredCount, 32'd1);

        // Stall hold over a valid write
        applyStimulus("stallCap", 1, 1, 0, 1, 0, 0, 32'h12, 32'h99, 5'd4, 5'd3);
        for (int i = 0; i < 4; i++)
            applyStimulus("stallHold", 1, 1, 1, 0, 1, 0, 32'hFF, 32'hEE, 5'd8, 5'd8);
        checkVal("stall.writeData.const", writeData, 32'h12);
        checkVal("stall.count.const", retiredCount, 32'd2);
        idle("stallRelease");

        // Write to $zero still retires
        applyStimulus("zeroReg", 1, 1, 0, 0, 0, 0, 32'h77, 32'h0, 5'd0, 5'd6);
        idle("zeroRetire");

        // Flush together with stall over a pending write
        applyStimulus("flushCap", 1, 1, 0, 1, 0, 0, 32'h44, 32'h0, 5'd0, 5'd12);
        applyStimulus("flushStall", 1, 1, 0, 1, 1, 1, 32'h45, 32'h0, 5'd0, 5'd13);
        idle("flushAfter");

        // Bypass history
        applyStimulus("bypCap", 1, 1, 0, 1, 0, 0, 32'h55, 32'h0, 5'd1, 5'd7);
        idle("bypNext");
`ifdef WB_BYPASS_EN
        checkVal("bypass.valid.const", {31'd0, bypassValid}, 32'd1);
        checkVal("bypass.reg.const", {27'd0, bypassRegister}, 32'd7);
        checkVal("bypass.data.const", bypassData, 32'h55);
`endif
        idle("bypClear");

        // Counter wrap on the 4-bit instance: 17 retirements from reset
        @(negedge clk);
        doReset();
        for (int i = 0; i < 17; i++)
            applyStimulus("wrap", 1, i[0], 0, 0, 0, 0, i, 32'd0, i[4:0], 5'd0);
        idle("wrapEnd");
        checkVal("wrap.smallCount.const", {28'd0, sRetiredCount}, 32'd1);
        checkVal("wrap.count.const", retiredCount, 32'd17);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus("random",
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom, $urandom,
                          5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)));
        end
        idle("drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
